// File: rtl/interval_timer_pkg.sv
// Shared constants and types for the interval timer.
// It provides the interval selectors, the default durations and the countdown state.
package interval_timer_pkg;

    localparam int SEL_BASE = 0;
    localparam int SEL_EXT  = 1;
    localparam int SEL_YEL  = 2;

    localparam int DEF_BASE = 6;
    localparam int DEF_EXT  = 3;
    localparam int DEF_YEL  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_e;

endpackage

// File: rtl/interval_param_store.sv
// Programmable duration registers with zero clamping and out-of-range write rejection.
// Provides a registered readback and a combinational read port for timer loads.
module interval_param_store
    import interval_timer_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int NUM_INTERVALS = 3,
    parameter int SEL_WIDTH     = 2,
    parameter logic [NUM_INTERVALS*WIDTH-1:0] DEFAULT_VALUES =
        {WIDTH'(DEF_YEL), WIDTH'(DEF_EXT), WIDTH'(DEF_BASE)}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prog,
    input  logic [SEL_WIDTH-1:0] tp_sel,
    input  logic [WIDTH-1:0]     time_value,
    input  logic [SEL_WIDTH-1:0] interval,
    output logic [WIDTH-1:0]     value,
    output logic [WIDTH-1:0]     rd_value,
    output logic                 rd_valid
);

    logic [WIDTH-1:0] param_q [NUM_INTERVALS];
    logic [WIDTH-1:0] param_d [NUM_INTERVALS];
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    function automatic logic [WIDTH-1:0] clamp_zero(input logic [WIDTH-1:0] v);
        return (v == '0) ? WIDTH'(1) : v;
    endfunction

    // Selectors that match no slot simply fall through, rejecting the write.
    always_comb begin
        for (int i = 0; i < NUM_INTERVALS; i++) begin
            param_d[i] = param_q[i];
            if (prog && (tp_sel == SEL_WIDTH'(i))) begin
                param_d[i] = clamp_zero(time_value);
            end
        end
    end

    always_comb begin
        rd_value = '1;
        rd_valid = 1'b0;
        for (int i = 0; i < NUM_INTERVALS; i++) begin
            if (interval == SEL_WIDTH'(i)) begin
                rd_value = param_q[i];
                rd_valid = 1'b1;
            end
        end
        value_d = rd_value;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_INTERVALS; i++) begin
                param_q[i] <= DEFAULT_VALUES[i*WIDTH +: WIDTH];
            end
            value_q <= '0;
        end else begin
            for (int i = 0; i < NUM_INTERVALS; i++) begin
                param_q[i] <= param_d[i];
            end
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/interval_timer.sv
// Timing-parameter store plus a one-second countdown with a single-cycle expiry pulse.
// A start always outranks a tick, so a start in the final-tick cycle is a plain restart.
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int NUM_INTERVALS = 3,
    parameter int SEL_WIDTH     = 2,
    parameter logic [NUM_INTERVALS*WIDTH-1:0] DEFAULT_VALUES =
        {WIDTH'(DEF_YEL), WIDTH'(DEF_EXT), WIDTH'(DEF_BASE)}
) (
    input  logic                 clock,
    input  logic                 Reset_Sync,
    input  logic                 Prog_Sync,
    input  logic [SEL_WIDTH-1:0] TP_Selector,
    input  logic [WIDTH-1:0]     Time_Value,
    input  logic [SEL_WIDTH-1:0] Interval,
    input  logic                 Start_Timer,
    input  logic                 One_Hz_Enable,
    output logic [WIDTH-1:0]     Value,
    output logic [WIDTH-1:0]     Remaining,
    output logic                 Busy,
    output logic                 Expired
);

    logic [WIDTH-1:0] load_value;
    logic             load_valid;

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             expired_q, expired_d;

    interval_param_store #(
        .WIDTH          (WIDTH),
        .NUM_INTERVALS  (NUM_INTERVALS),
        .SEL_WIDTH      (SEL_WIDTH),
        .DEFAULT_VALUES (DEFAULT_VALUES)
    ) u_store (
        .clk        (clock),
        .rst        (Reset_Sync),
        .prog       (Prog_Sync),
        .tp_sel     (TP_Selector),
        .time_value (Time_Value),
        .interval   (Interval),
        .value      (Value),
        .rd_value   (load_value),
        .rd_valid   (load_valid)
    );

    // load_value is the pre-write parameter, so a same-cycle program never leaks into a start.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        expired_d   = 1'b0;
        if (Start_Timer) begin
            if (load_valid) begin
                remaining_d = load_value;
                state_d     = RUN;
            end
        end else if ((state_q == RUN) && One_Hz_Enable) begin
            if (remaining_q > WIDTH'(1)) begin
                remaining_d = remaining_q - WIDTH'(1);
            end else begin
                remaining_d = '0;
                state_d     = IDLE;
                expired_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (Reset_Sync) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
        end
    end

    assign Remaining = remaining_q;
    assign Busy      = (state_q == RUN);
    assign Expired   = expired_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed and randomized bench for interval_timer.
// Every cycle is checked against a behavioural model of the parameter table and the countdown.
module tb_interval_timer;
    import interval_timer_pkg::*;

    localparam int N = 3;

    logic       clock = 1'b0;
    logic       Reset_Sync = 1'b0;
    logic       Prog_Sync = 1'b0;
    logic [1:0] TP_Selector = '0;
    logic [3:0] Time_Value = '0;
    logic [1:0] Interval = '0;
    logic       Start_Timer = 1'b0;
    logic       One_Hz_Enable = 1'b0;
    logic [3:0] Value;
    logic [3:0] Remaining;
    logic       Busy;
    logic       Expired;

    int n_cmp = 0;
    int n_bad = 0;

    int prm [N];
    int m_val = 0;
    int m_rem = 0;
    bit m_busy = 0;
    bit m_exp = 0;
    int n_expired = 0;

    interval_timer dut (
        .clock         (clock),
        .Reset_Sync    (Reset_Sync),
        .Prog_Sync     (Prog_Sync),
        .TP_Selector   (TP_Selector),
        .Time_Value    (Time_Value),
        .Interval      (Interval),
        .Start_Timer   (Start_Timer),
        .One_Hz_Enable (One_Hz_Enable),
        .Value         (Value),
        .Remaining     (Remaining),
        .Busy          (Busy),
        .Expired       (Expired)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === 32'(exp)) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, advance the model from the pre-edge state, then compare.
    task automatic cyc(input bit rst, input bit prog, input int sel, input int tv,
                       input int intv, input bit start, input bit tick);
        Reset_Sync    = rst;
        Prog_Sync     = prog;
        TP_Selector   = 2'(sel);
        Time_Value    = 4'(tv);
        Interval      = 2'(intv);
        Start_Timer   = start;
        One_Hz_Enable = tick;
        if (rst) begin
            prm    = '{6, 3, 2};
            m_val  = 0;
            m_rem  = 0;
            m_busy = 0;
            m_exp  = 0;
        end else begin
            m_val = (intv < N) ? prm[intv] : 15;
            m_exp = 0;
            if (start) begin
                if (intv < N) begin
                    m_rem  = prm[intv];
                    m_busy = 1;
                end
            end else if (m_busy && tick) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_exp  = 1;
                end
            end
            if (prog && sel < N) prm[sel] = (tv == 0) ? 1 : tv;
        end
        if (m_exp) n_expired++;
        @(posedge clock);
        #1;
        chk("value", 32'(Value), m_val);
        chk("remaining", 32'(Remaining), m_rem);
        chk("busy", 32'(Busy), int'(m_busy));
        chk("expired", 32'(Expired), int'(m_exp));
    endtask

    task automatic idle(input int intv, input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, intv, 0, 0);
    endtask

    task automatic tick_spaced(input int intv, input int ticks);
        for (int i = 0; i < ticks; i++) begin
            cyc(0, 0, 0, 0, intv, 0, 1);
            idle(intv, 2);
        end
    endtask

    initial begin
        int exp_before;
        bit r_start, r_tick;
        int r_intv;

        // Reset and default readback, including out-of-range selector
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(SEL_BASE, 2);
        idle(SEL_EXT, 2);
        idle(SEL_YEL, 2);
        idle(3, 2);
        chk("default_yel_oor", 32'(Value), 15);

        // Zero clamp and rejected write
        cyc(0, 1, SEL_EXT, 0, SEL_EXT, 0, 0);
        idle(SEL_EXT, 2);
        chk("ext_clamped", 32'(Value), 1);
        cyc(0, 1, 3, 9, SEL_BASE, 0, 0);
        idle(SEL_BASE, 2);
        idle(SEL_EXT, 2);
        idle(SEL_YEL, 2);

        // Full countdown on base with exactly one expiry
        exp_before = n_expired;
        cyc(0, 0, 0, 0, SEL_BASE, 1, 0);
        chk("base_loaded", 32'(Remaining), 6);
        tick_spaced(SEL_BASE, 6);
        chk("base_expired_once", 32'(n_expired - exp_before), 1);
        tick_spaced(SEL_BASE, 2);

        // Restart on yellow with a coincident tick
        cyc(0, 0, 0, 0, SEL_BASE, 1, 0);
        tick_spaced(SEL_BASE, 2);
        cyc(0, 0, 0, 0, SEL_YEL, 1, 1);
        chk("restart_yel", 32'(Remaining), 2);
        tick_spaced(SEL_YEL, 2);

        // Start and program on the same index: pre-write value loads
        cyc(0, 1, SEL_BASE, 9, SEL_BASE, 1, 0);
        chk("prewrite_load", 32'(Remaining), 6);
        tick_spaced(SEL_BASE, 1);
        cyc(0, 0, 0, 0, SEL_BASE, 1, 0);
        chk("postwrite_load", 32'(Remaining), 9);

        // Start coinciding with the final tick is a restart
        cyc(0, 0, 0, 0, SEL_YEL, 1, 0);
        tick_spaced(SEL_YEL, 1);
        exp_before = n_expired;
        cyc(0, 0, 0, 0, SEL_YEL, 1, 1);
        idle(SEL_YEL, 2);
        chk("restart_no_expire", 32'(n_expired - exp_before), 0);

        // Reset mid-countdown aborts silently and restores defaults
        cyc(0, 0, 0, 0, SEL_BASE, 1, 0);
        tick_spaced(SEL_BASE, 6);
        chk("rem_before_reset", 32'(Remaining), 3);
        cyc(1, 0, 0, 0, SEL_BASE, 0, 1);
        idle(SEL_BASE, 3);
        idle(SEL_EXT, 2);
        chk("ext_default_again", 32'(Value), 3);

        // Randomized traffic; an ignored start never shares a cycle with a tick
        for (int i = 0; i < 600; i++) begin
            r_intv  = int'($urandom_range(0, 3));
            r_start = ($urandom_range(0, 9) == 0);
            r_tick  = ($urandom_range(0, 2) == 0);
            if (r_start && r_intv >= N) r_tick = 0;
            cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                r_intv, r_start, r_tick);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
# interval_timer

Parametrised timing-parameter store and countdown timer for the traffic-light controller. It holds NUM_INTERVALS programmable durations (base, extension, yellow, plus optional extra phases) and lets the controller FSM read them back. It also runs a countdown on any selected interval, driven by the system one-second enable, and flags expiry with a single-cycle pulse. It sits between the programming/sync front end and the light-sequencing FSM.

## Interface
- WIDTH, 4: bit width of each duration, in seconds.
- NUM_INTERVALS, 3: number of programmable intervals. Must be ≥ 2 and ≤ 2**SEL_WIDTH.
- SEL_WIDTH, 2: width of the selector buses.
- DEFAULT_VALUES, {4'd2,4'd3,4'd6}: packed NUM_INTERVALS×WIDTH reset values. Index 0 is in the LSBs: 0 = base 6, 1 = ext 3, 2 = yellow 2.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- Reset_Sync  in  1  synchronous reset, active-high.
- Prog_Sync  in  1  write strobe for programming, already synchronised.
- TP_Selector  in  SEL_WIDTH  index of the interval to program.
- Time_Value  in  WIDTH  duration to program.
- Interval  in  SEL_WIDTH  index used for readback and for timer start.
- Start_Timer  in  1  loads the countdown from interval Interval.
- One_Hz_Enable  in  1  single-cycle tick, once per second.
- Value  out  WIDTH  registered readback of the duration for Interval.
- Remaining  out  WIDTH  current countdown value.
- Busy  out  1  countdown active.
- Expired  out  1  one-cycle pulse when the countdown reaches zero.

## Operation
- **Reset.** Reset_Sync takes priority over all other inputs.
  - Every parameter register returns to its DEFAULT_VALUES slice.
  - Value, Remaining, Busy and Expired all reset to 0.
- **Programming.** When Prog_Sync=1 and TP_Selector < NUM_INTERVALS, param[TP_Selector] is written with Time_Value.
  - A Time_Value of 0 is clamped to 1.
  - If TP_Selector ≥ NUM_INTERVALS, the write is ignored and no register changes.
- **Readback.** Value is updated every cycle to param[Interval].
  - If Interval ≥ NUM_INTERVALS, Value is all ones.
- **Countdown.** The timer has two states, IDLE and RUN.
  - Start_Timer=1 with a valid Interval:
    - Remaining is loaded with param[Interval] and the state becomes RUN.
    - This applies in any state. A start during RUN restarts the countdown.
  - Start_Timer=1 with an out-of-range Interval is ignored; the state and Remaining are unchanged.
  - In RUN, on One_Hz_Enable with no start:
    - If Remaining > 1, Remaining decrements by 1.
    - If Remaining = 1, Remaining becomes 0, the state becomes IDLE and Expired is set for exactly one cycle.
  - In IDLE, One_Hz_Enable has no effect.
- **Busy.** Busy = (state == RUN).
- **Arithmetic.** All arithmetic is unsigned WIDTH-bit. Remaining never wraps below 0.

## Timing
- Value has 1-cycle latency from a change on Interval. It reflects a programming write 1 cycle after that write.
- **Start_Timer at edge t:**
  - Remaining holds the loaded value and Busy=1 after edge t.
  - A duration of N requires N One_Hz_Enable ticks after the load.
  - Expired=1 after the edge that samples the Nth tick, with Busy=0 in that same cycle. Expired drops after the next edge.
- **Same-cycle cases:**
  - Start and One_Hz_Enable together: start wins, and that tick is not counted.
  - Start and Prog_Sync to the same index together: the timer loads the pre-write value. The new value applies from the next start.
  - Start together with the final tick: this is a restart. Expired is not pulsed.
- Reset during RUN aborts the countdown with no Expired pulse.
- Programming during RUN does not affect the countdown in progress.

## Structure
- **Package interval_timer_pkg** holds:
  - selector constants SEL_BASE=0, SEL_EXT=1, SEL_YEL=2;
  - the default duration constants 6/3/2;
  - a state enum {IDLE, RUN}.
- **Sub-module interval_param_store** contains:
  - the parameter register array;
  - zero clamping and out-of-range write rejection;
  - the registered Value readback;
  - an unregistered read port (param[Interval]) for the timer load.
- **Top level** contains the countdown FSM and the Remaining/Busy/Expired registers.

## Test plan
1. Reset, then read back intervals 0..2 → Value = 6, 3, 2. Interval=3 → Value=4'hF.
2. Program TP_Selector=1 with Time_Value=0 → ext reads 1. Program TP_Selector=3 with Time_Value=9 → all registers unchanged.
3. Start on base (6), then apply 6 ticks spaced 3 cycles apart → Remaining steps 6, 5, ..., 1, 0. Exactly one Expired pulse after the 6th tick. Busy high from the load until that tick.
4. Restart on yellow (2) while base is at 4, with a tick in the same cycle → Remaining=2. Two further ticks give Expired.
5. Program base=9 in the same cycle as a start on base → Remaining=6. The next start loads 9.
6. Reset_Sync asserted at Remaining=3 → Busy=0, Remaining=0, no Expired, parameters back to defaults.
